// File: rtl/rcb_arb.sv
// rcb_arb: RAM Control Block arbiter.
// Shares one single-port RAM between the tick-path lookup reads (priority)
// and host configuration writes. A pending write may lose to reads for at
// most WR_STARVE_MAX consecutive cycles; after that, lkp_rd_ready drops for
// one cycle and the write is forced through.
//
// Ports:
//   clk, reset_n          core clock, async active-low reset
//   lkp_rd_*              lookup read request/ready, returned valid/data
//   hpb_wr_*              host write request (level) with addr/data/byte-en
//   rcb_wr_done           one-cycle pulse when the host write has completed
//   ram_*                 single-port RAM interface (RAM registers the read)
//   starve_events         saturating count of forced writes
`timescale 1ns/1ps
module rcb_arb #(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 64,
  parameter int BE_W          = DATA_W/8,
  parameter int RAM_RD_LAT    = 1,
  parameter int WR_STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              lkp_rd_req,
  input  logic [ADDR_W-1:0] lkp_rd_addr,
  output logic              lkp_rd_ready,
  output logic              lkp_rd_valid,
  output logic [DATA_W-1:0] lkp_rd_data,
  input  logic              hpb_wr_req,
  input  logic [ADDR_W-1:0] hpb_wr_addr,
  input  logic [DATA_W-1:0] hpb_wr_data,
  input  logic [BE_W-1:0]   hpb_wr_byte_en,
  output logic              rcb_wr_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [BE_W-1:0]   ram_be,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       starve_events
);

  localparam int CNT_W = $clog2(WR_STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX_C = CNT_W'(WR_STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_starve_cnt;
  logic [CNT_W-1:0]      w_starve_cnt_nxt;
  logic [RAM_RD_LAT-1:0] r_rd_vld;
  logic [15:0]           r_starve_events;
  logic                  w_rd_go;
  logic                  w_wr_go;
  logic                  w_forced;

  // Ready depends on registered state only: it drops in the one cycle where
  // the starved write must win.
  assign lkp_rd_ready = !((r_state == ST_PEND) && (r_starve_cnt == STARVE_MAX_C));

  // reset_n gates the grants so the RAM port stays quiet while in reset.
  assign w_rd_go  = reset_n && lkp_rd_req && lkp_rd_ready;
  assign w_wr_go  = reset_n && ((r_state == ST_IDLE) || (r_state == ST_PEND)) &&
                    hpb_wr_req && !w_rd_go;
  assign w_forced = w_wr_go && !lkp_rd_ready;

  assign rcb_wr_done   = (r_state == ST_DONE);
  assign lkp_rd_valid  = r_rd_vld[RAM_RD_LAT-1];
  assign lkp_rd_data   = ram_rdata;
  assign starve_events = r_starve_events;

  // RAM port mux: read has priority, write otherwise, idle port if neither.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_be    = '0;
    if (w_rd_go) begin
      ram_en   = 1'b1;
      ram_addr = lkp_rd_addr;
    end else if (w_wr_go) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = hpb_wr_addr;
      ram_wdata = hpb_wr_data;
      ram_be    = hpb_wr_byte_en;
    end else begin
      ram_en = 1'b0;
    end
  end

  // Next-state and starvation-counter logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_starve_cnt_nxt = r_starve_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_go) begin
          w_state_nxt = ST_DONE;
        end else if (hpb_wr_req && w_rd_go) begin
          w_state_nxt      = ST_PEND;
          w_starve_cnt_nxt = CNT_W'(1);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (!hpb_wr_req) begin
          // Host withdrew the request: abort with no write and no done.
          w_state_nxt      = ST_IDLE;
          w_starve_cnt_nxt = '0;
        end else if (w_wr_go) begin
          w_state_nxt      = ST_DONE;
          w_starve_cnt_nxt = '0;
        end else if (r_starve_cnt != STARVE_MAX_C) begin
          w_starve_cnt_nxt = r_starve_cnt + CNT_W'(1);
        end else begin
          w_starve_cnt_nxt = r_starve_cnt;
        end
      end
      ST_DONE: begin
        // A still-high request is the same message; hold until it drops.
        if (hpb_wr_req) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!hpb_wr_req) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt      = ST_IDLE;
        w_starve_cnt_nxt = '0;
      end
    endcase
  end

  // State and starvation-counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
    end
  end

  // Read-valid shift register matching the RAM read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_vld <= '0;
    end else begin
      r_rd_vld[0] <= w_rd_go;
      for (int i = 1; i < RAM_RD_LAT; i++) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
      end
    end
  end

  // Saturating count of forced writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_events <= 16'h0000;
    end else if (w_forced && (r_starve_events != 16'hFFFF)) begin
      r_starve_events <= r_starve_events + 16'h0001;
    end else begin
      r_starve_events <= r_starve_events;
    end
  end

endmodule

// File: tb/tb_rcb_arb.sv
// tb_rcb_arb: directed testbench for rcb_arb with a behavioural 1-cycle RAM.
`timescale 1ns/1ps
module tb_rcb_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        lkp_rd_req;
  logic [9:0]  lkp_rd_addr;
  logic        lkp_rd_ready;
  logic        lkp_rd_valid;
  logic [63:0] lkp_rd_data;
  logic        hpb_wr_req;
  logic [9:0]  hpb_wr_addr;
  logic [63:0] hpb_wr_data;
  logic [7:0]  hpb_wr_byte_en;
  logic        rcb_wr_done;
  logic        ram_en;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [63:0] ram_wdata;
  logic [7:0]  ram_be;
  logic [63:0] ram_rdata;
  logic [15:0] starve_events;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int vld_cnt = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int s_acc, s_vld, s_we, s_done;

  logic [63:0] mem [0:1023];
  logic [63:0] r_q;

  rcb_arb #(
    .ADDR_W(10), .DATA_W(64), .BE_W(8), .RAM_RD_LAT(1), .WR_STARVE_MAX(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .lkp_rd_req(lkp_rd_req), .lkp_rd_addr(lkp_rd_addr),
    .lkp_rd_ready(lkp_rd_ready), .lkp_rd_valid(lkp_rd_valid),
    .lkp_rd_data(lkp_rd_data),
    .hpb_wr_req(hpb_wr_req), .hpb_wr_addr(hpb_wr_addr),
    .hpb_wr_data(hpb_wr_data), .hpb_wr_byte_en(hpb_wr_byte_en),
    .rcb_wr_done(rcb_wr_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata),
    .starve_events(starve_events)
  );

  always #5 clk = ~clk;

  // Single-port RAM, registered read, byte-enabled write.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 8; b++) begin
          if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end
      end else begin
        r_q <= mem[ram_addr];
      end
    end
  end
  assign ram_rdata = r_q;

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_en && !ram_we) acc_cnt <= acc_cnt + 1;
    if (ram_en && ram_we)  we_cnt  <= we_cnt + 1;
    if (lkp_rd_valid)      vld_cnt <= vld_cnt + 1;
    if (rcb_wr_done)       done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_acc = acc_cnt; s_vld = vld_cnt; s_we = we_cnt; s_done = done_cnt;
  endtask

  initial begin
    reset_n = 1'b0;
    lkp_rd_req = 1'b0; lkp_rd_addr = 10'h000;
    hpb_wr_req = 1'b0; hpb_wr_addr = 10'h000;
    hpb_wr_data = 64'h0; hpb_wr_byte_en = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_ready", 64'(lkp_rd_ready), 64'd1);
    chk("rst_done", 64'(rcb_wr_done), 64'd0);
    chk("rst_valid", 64'(lkp_rd_valid), 64'd0);
    chk("rst_events", 64'(starve_events), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    nxt();

    // Idle write then read back
    hpb_wr_req = 1'b1; hpb_wr_addr = 10'h005;
    hpb_wr_data = 64'h0000_0000_DEAD_BEEF; hpb_wr_byte_en = 8'hFF;
    #1;
    chk("iw_en", 64'(ram_en), 64'd1);
    chk("iw_we", 64'(ram_we), 64'd1);
    chk("iw_addr", 64'(ram_addr), 64'h005);
    chk("iw_wdata", ram_wdata, 64'h0000_0000_DEAD_BEEF);
    chk("iw_done0", 64'(rcb_wr_done), 64'd0);
    nxt();
    hpb_wr_req = 1'b0;
    #1;
    chk("iw_done1", 64'(rcb_wr_done), 64'd1);
    chk("iw_we_c1", 64'(ram_we), 64'd0);
    nxt();
    lkp_rd_req = 1'b1; lkp_rd_addr = 10'h005;
    #1;
    chk("iw_done2", 64'(rcb_wr_done), 64'd0);
    chk("rd_en", 64'(ram_en), 64'd1);
    chk("rd_we", 64'(ram_we), 64'd0);
    chk("rd_addr", 64'(ram_addr), 64'h005);
    nxt();
    lkp_rd_req = 1'b0;
    #1;
    chk("rd_valid", 64'(lkp_rd_valid), 64'd1);
    chk("rd_data", lkp_rd_data, 64'h0000_0000_DEAD_BEEF);
    nxt();
    chk("rd_valid_off", 64'(lkp_rd_valid), 64'd0);

    // Contention: continuous reads starve a write for 16 grants
    snap();
    lkp_rd_req = 1'b1; lkp_rd_addr = 10'h100;
    hpb_wr_req = 1'b1; hpb_wr_addr = 10'h007;
    hpb_wr_data = 64'hA5A5_A5A5_A5A5_A5A5; hpb_wr_byte_en = 8'hFF;
    #1;
    chk("ct_ready_c0", 64'(lkp_rd_ready), 64'd1);
    chk("ct_we_c0", 64'(ram_we), 64'd0);
    for (int c = 1; c < 16; c++) begin
      nxt();
      lkp_rd_addr = 10'(256 + c);
    end
    nxt();
    #1;
    chk("ct_ready_c16", 64'(lkp_rd_ready), 64'd0);
    chk("ct_we_c16", 64'(ram_we), 64'd1);
    chk("ct_addr_c16", 64'(ram_addr), 64'h007);
    chk("ct_grants", 64'(acc_cnt - s_acc), 64'd16);
    nxt();
    hpb_wr_req = 1'b0;
    #1;
    chk("ct_done", 64'(rcb_wr_done), 64'd1);
    chk("ct_events", 64'(starve_events), 64'd1);
    chk("ct_ready_c17", 64'(lkp_rd_ready), 64'd1);
    nxt();
    lkp_rd_req = 1'b0;
    #1;
    chk("ct_done_off", 64'(rcb_wr_done), 64'd0);
    nxt();
    nxt();
    chk("ct_acc_total", 64'(acc_cnt - s_acc), 64'd17);
    chk("ct_vld_total", 64'(vld_cnt - s_vld), 64'd17);
    chk("ct_we_total", 64'(we_cnt - s_we), 64'd1);
    chk("ct_done_total", 64'(done_cnt - s_done), 64'd1);

    // Gap in reads at starve_cnt=3 lets the write through
    lkp_rd_req = 1'b1; lkp_rd_addr = 10'h200;
    hpb_wr_req = 1'b1; hpb_wr_addr = 10'h008;
    hpb_wr_data = 64'h0808_0808_0808_0808; hpb_wr_byte_en = 8'hFF;
    nxt();
    nxt();
    nxt();
    lkp_rd_req = 1'b0;
    #1;
    chk("gap_we", 64'(ram_we), 64'd1);
    chk("gap_addr", 64'(ram_addr), 64'h008);
    chk("gap_ready", 64'(lkp_rd_ready), 64'd1);
    nxt();
    hpb_wr_req = 1'b0;
    #1;
    chk("gap_done", 64'(rcb_wr_done), 64'd1);
    chk("gap_events", 64'(starve_events), 64'd1);
    nxt();

    // Held request: one write only until req drops
    snap();
    hpb_wr_req = 1'b1; hpb_wr_addr = 10'h009;
    hpb_wr_data = 64'h0909_0909_0909_0909; hpb_wr_byte_en = 8'hFF;
    repeat (11) nxt();
    hpb_wr_req = 1'b0;
    #1;
    chk("hold_we_cnt", 64'(we_cnt - s_we), 64'd1);
    chk("hold_done_cnt", 64'(done_cnt - s_done), 64'd1);
    chk("hold_we_now", 64'(ram_we), 64'd0);
    nxt();
    hpb_wr_req = 1'b1; hpb_wr_addr = 10'h006;
    hpb_wr_data = 64'h0606_0606_0606_0606;
    #1;
    chk("hold_we2", 64'(ram_we), 64'd1);
    chk("hold_addr2", 64'(ram_addr), 64'h006);
    nxt();
    hpb_wr_req = 1'b0;
    #1;
    chk("hold_done2", 64'(rcb_wr_done), 64'd1);
    nxt();
    chk("hold_we_cnt2", 64'(we_cnt - s_we), 64'd2);
    chk("hold_done_cnt2", 64'(done_cnt - s_done), 64'd2);

    // Abort in PEND
    snap();
    lkp_rd_req = 1'b1; lkp_rd_addr = 10'h030;
    hpb_wr_req = 1'b1; hpb_wr_addr = 10'h003;
    nxt();
    lkp_rd_req = 1'b0; hpb_wr_req = 1'b0;
    #1;
    chk("ab_en", 64'(ram_en), 64'd0);
    nxt();
    chk("ab_done", 64'(rcb_wr_done), 64'd0);
    nxt();
    chk("ab_we_cnt", 64'(we_cnt - s_we), 64'd0);
    chk("ab_done_cnt", 64'(done_cnt - s_done), 64'd0);

    // Async reset in PEND
    lkp_rd_req = 1'b1; hpb_wr_req = 1'b1;
    nxt();
    #1;
    chk("ar_valid_pre", 64'(lkp_rd_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("ar_valid", 64'(lkp_rd_valid), 64'd0);
    chk("ar_en", 64'(ram_en), 64'd0);
    chk("ar_we", 64'(ram_we), 64'd0);
    chk("ar_ready", 64'(lkp_rd_ready), 64'd1);
    chk("ar_done", 64'(rcb_wr_done), 64'd0);
    chk("ar_events", 64'(starve_events), 64'd0);
    lkp_rd_req = 1'b0; hpb_wr_req = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    nxt();
    chk("ar_done_after", 64'(rcb_wr_done), 64'd0);

    // Byte enables and read-after-write
    hpb_wr_req = 1'b1; hpb_wr_addr = 10'h00A;
    hpb_wr_data = 64'h1111_1111_1111_1111; hpb_wr_byte_en = 8'hFF;
    nxt();
    hpb_wr_req = 1'b0;
    nxt();
    hpb_wr_req = 1'b1; hpb_wr_data = 64'h2222_2222_2222_2222;
    hpb_wr_byte_en = 8'h0F;
    #1;
    chk("be_be", 64'(ram_be), 64'h0F);
    nxt();
    hpb_wr_req = 1'b0;
    lkp_rd_req = 1'b1; lkp_rd_addr = 10'h00A;
    #1;
    chk("be_done", 64'(rcb_wr_done), 64'd1);
    nxt();
    lkp_rd_req = 1'b0;
    #1;
    chk("be_valid", 64'(lkp_rd_valid), 64'd1);
    chk("be_data", lkp_rd_data, 64'h1111_1111_2222_2222);
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
